// File: rtl/jk_pkg.sv
// Shared types for the JK-flip-flop counter: the per-bit {J,K} command encoding
// and a helper that turns a data bit into a load-style command.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_t;

  // Load-style command: J=d, K=~d forces the flop to d regardless of its state.
  function automatic jk_cmd_t jk_load(input bit d);
    return d ? JK_SET : JK_RESET;
  endfunction

  // Counting command: J=K=t toggles when t is set and holds otherwise.
  function automatic jk_cmd_t jk_count(input logic t);
    return t ? JK_TOGGLE : JK_HOLD;
  endfunction

endpackage

// File: rtl/jk_sync_counter_if.sv
// Control and status bundle of the JK counter; the master drives the controls,
// the slave (the counter) returns count, complement, terminal count and wrap.
interface jk_sync_counter_if #(
  parameter int WIDTH = 4
);

  logic             EN;
  logic             UP;
  logic             LD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] not_Q;
  logic             TC;
  logic             WRAP;

  modport master (
    output EN, UP, LD, D,
    input  Q, not_Q, TC, WRAP
  );

  modport slave (
    input  EN, UP, LD, D,
    output Q, not_Q, TC, WRAP
  );

endinterface

// File: rtl/jk_ff.sv
// Edge-triggered JK flip-flop cell with true and complementary outputs.
// It has no reset pin: clearing is done by presenting the JK_RESET command.
module jk_ff
  import jk_pkg::*;
(
  input  logic clk,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic not_Q
);

  jk_cmd_t cmd;
  logic    q_q;
  logic    q_d;

  assign cmd = jk_cmd_t'({J, K});

  // NOTE: combinational blocks use blocking '=' and assign a default first so
  // no path leaves q_d unassigned, which would otherwise infer a latch.
  always_comb begin
    q_d = q_q;
    unique case (cmd)
      JK_HOLD:   q_d = q_q;
      JK_RESET:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
      default:   q_d = q_q;
    endcase
  end

  // NOTE: state flops use non-blocking '<='; this flop is deliberately left
  // without a reset branch because reset arrives through the J/K command path.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign Q     = q_q;
  assign not_Q = ~q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous modulo-MODULUS up/down counter built from WIDTH JK cells; every
// state change (reset, load, count, wrap) is expressed as a per-bit J/K command.
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic               clk,
  input  logic               reset,
  jk_sync_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] not_q;
  jk_cmd_t          cmd [WIDTH];
  logic             at_top;
  logic             at_zero;
  logic             wrap_q;
  logic             wrap_d;

  // ">=" rather than "==" so an out-of-range loaded value still wraps to 0.
  assign at_top  = (q >= TOP_VAL);
  assign at_zero = (q == '0);

  // Per-bit command mux in priority order: reset, load, count, hold.
  always_comb begin
    logic carry;
    logic borrow;
    for (int i = 0; i < WIDTH; i++) cmd[i] = JK_HOLD;
    wrap_d = 1'b0;
    carry  = 1'b1;
    borrow = 1'b1;

    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cmd[i] = JK_RESET;
    end else if (bus.LD) begin
      for (int i = 0; i < WIDTH; i++) cmd[i] = jk_load(bus.D[i]);
    end else if (bus.EN) begin
      if (bus.UP) begin
        if (at_top) begin
          for (int i = 0; i < WIDTH; i++) cmd[i] = jk_load(1'b0);
          wrap_d = 1'b1;
        end else begin
          // Bit i toggles when all lower bits are one.
          for (int i = 0; i < WIDTH; i++) begin
            cmd[i] = jk_count(carry);
            carry  = carry & q[i];
          end
        end
      end else begin
        if (at_zero) begin
          for (int i = 0; i < WIDTH; i++) cmd[i] = jk_load(TOP_VAL[i]);
          wrap_d = 1'b1;
        end else begin
          // Bit i toggles when all lower bits are zero.
          for (int i = 0; i < WIDTH; i++) begin
            cmd[i] = jk_count(borrow);
            borrow = borrow & not_q[i];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_ff u_ff (
      .clk   (clk),
      .J     (cmd[g][1]),
      .K     (cmd[g][0]),
      .Q     (q[g]),
      .not_Q (not_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) wrap_q <= 1'b0;
    else       wrap_q <= wrap_d;
  end

  assign bus.Q     = q;
  assign bus.not_Q = not_q;
  assign bus.TC    = bus.UP ? at_top : at_zero;
  assign bus.WRAP  = wrap_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Scoreboard bench for jk_sync_counter: a decimal (MODULUS=10) and a full
// binary (MODULUS=16) instance share clock and reset; a monitor checks each edge.
module tb_jk_sync_counter;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  jk_sync_counter_if #(.WIDTH(4)) bus0 ();
  jk_sync_counter_if #(.WIDTH(4)) bus1 ();

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) u_dec (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  jk_sync_counter #(.WIDTH(4), .MODULUS(16)) u_bin (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    int         sel;
    string      tag;
    logic [3:0] q;
    logic       wrap;
    logic       tc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: after every rising edge, compare the DUT against queued expectations.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] q, nq;
      logic w, t;
      e = exp_q.pop_front();
      if (e.sel == 0) begin
        q = bus0.Q; nq = bus0.not_Q; w = bus0.WRAP; t = bus0.TC;
      end else begin
        q = bus1.Q; nq = bus1.not_Q; w = bus1.WRAP; t = bus1.TC;
      end
      check({e.tag, " Q"},     q,          e.q);
      check({e.tag, " not_Q"}, nq,         ~e.q);
      check({e.tag, " WRAP"},  {3'b0, w},  {3'b0, e.wrap});
      check({e.tag, " TC"},    {3'b0, t},  {3'b0, e.tc});
    end
  end

  task automatic expect_dut(input int sel, input string tag,
                            input logic [3:0] q, input logic wrap, input logic tc);
    exp_t e;
    e.sel = sel; e.tag = tag; e.q = q; e.wrap = wrap; e.tc = tc;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus on the selected counter (the other one idles),
  // followed by the expected post-edge response.
  task automatic step(input int sel, input string tag,
                      input logic rst, input logic ld, input logic en, input logic up,
                      input logic [3:0] d,
                      input logic [3:0] q, input logic wrap, input logic tc);
    @(negedge clk);
    #1;
    reset = rst;
    bus0.EN = 1'b0; bus0.LD = 1'b0;
    bus1.EN = 1'b0; bus1.LD = 1'b0;
    if (sel == 0) begin
      bus0.EN = en; bus0.LD = ld; bus0.UP = up; bus0.D = d;
    end else begin
      bus1.EN = en; bus1.LD = ld; bus1.UP = up; bus1.D = d;
    end
    @(posedge clk);
    #1;
    expect_dut(sel, tag, q, wrap, tc);
  endtask

  initial begin
    bus0.EN = 1'b0; bus0.UP = 1'b1; bus0.LD = 1'b0; bus0.D = '0;
    bus1.EN = 1'b0; bus1.UP = 1'b1; bus1.LD = 1'b0; bus1.D = '0;

    // Reset for two edges, then hold for three; both counters checked.
    for (int i = 0; i < 2; i++) begin
      step(0, "reset", 1, 0, 0, 1, 4'd0, 4'd0, 0, 0);
      expect_dut(1, "reset_bin", 4'd0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, "hold", 0, 0, 0, 1, 4'd0, 4'd0, 0, 0);
      expect_dut(1, "hold_bin", 4'd0, 0, 0);
    end

    // TC follows UP even while idle: down direction at Q=0.
    step(0, "tc_down_idle", 0, 0, 0, 0, 4'd0, 4'd0, 0, 1);

    // Up count 12 edges: 1..9, 0 (wrap), 1, 2.
    for (int i = 1; i <= 9; i++)
      step(0, "up", 0, 0, 1, 1, 4'd0, 4'(i), 0, (i == 9));
    step(0, "up_wrap", 0, 0, 1, 1, 4'd0, 4'd0, 1, 0);
    step(0, "up_after", 0, 0, 1, 1, 4'd0, 4'd1, 0, 0);
    step(0, "up_after2", 0, 0, 1, 1, 4'd0, 4'd2, 0, 0);

    // Down wrap from 0.
    step(0, "load0", 0, 1, 0, 0, 4'd0, 4'd0, 0, 1);
    step(0, "down_wrap", 0, 0, 1, 0, 4'd0, 4'd9, 1, 0);
    step(0, "down8", 0, 0, 1, 0, 4'd0, 4'd8, 0, 0);
    step(0, "down7", 0, 0, 1, 0, 4'd0, 4'd7, 0, 0);

    // Load wins over EN, out-of-range value wraps up, and decrements down.
    step(0, "ld13_up", 0, 1, 1, 1, 4'd13, 4'd13, 0, 1);
    step(0, "oor_wrap", 0, 0, 1, 1, 4'd0, 4'd0, 1, 0);
    step(0, "ld13_dn", 0, 1, 1, 0, 4'd13, 4'd13, 0, 0);
    step(0, "oor_dec", 0, 0, 1, 0, 4'd0, 4'd12, 0, 0);

    // Wrap followed at once by a load: no wrap pulse after the load.
    step(0, "ld9", 0, 1, 0, 1, 4'd9, 4'd9, 0, 1);
    step(0, "wrap9", 0, 0, 1, 1, 4'd0, 4'd0, 1, 0);
    step(0, "ld_after_wrap", 0, 1, 1, 1, 4'd5, 4'd5, 0, 0);

    // Reset mid-count beats LD and EN; counting resumes from 0.
    step(0, "ld6", 0, 1, 0, 1, 4'd6, 4'd6, 0, 0);
    step(0, "rst_mid", 1, 1, 1, 1, 4'd3, 4'd0, 0, 0);
    step(0, "resume", 0, 0, 1, 1, 4'd0, 4'd1, 0, 0);

    // Full binary counter: 17 up edges, natural overflow 15 -> 0.
    for (int i = 1; i <= 17; i++)
      step(1, "bin_up", 0, 0, 1, 1, 4'd0, 4'(i % 16), (i == 16), (i == 15));
    step(1, "bin_down_wrap", 0, 0, 1, 0, 4'd0, 4'd0, 0, 1);
    step(1, "bin_down", 0, 0, 1, 0, 4'd0, 4'd15, 1, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
